// File: rtl/regfile_pkg.sv
// Shared definitions for the register file slice.
// Contents: bulk-clear FSM state encoding and default width constants.
package regfile_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } sweep_state_e;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

endpackage

// File: rtl/regfile_scb_sweep.sv
// Bulk-clear sequencer for the register file.
// Ports:
//   clk, rst_n    clock / asynchronous active-low reset
//   clr_req_i     single-cycle pulse starting a sweep (ignored while sweeping)
//   clr_en_o      clear the entry at clr_addr_o this cycle
//   clr_addr_o    entry being cleared (the sweep index)
//   busy_o        sweep in progress
// The sweep visits entries 0..DEPTH-1, one per cycle, then returns to idle.
module regfile_scb_sweep
  import regfile_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_req_i,
  output logic              clr_en_o,
  output logic [ADDR_W-1:0] clr_addr_o,
  output logic              busy_o
);

  localparam logic [ADDR_W-1:0] LAST_IDX = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] ZERO_IDX = {ADDR_W{1'b0}};

  sweep_state_e      state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;

  // State and sweep-index registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= ZERO_IDX;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state logic: start on request, leave after clearing the last entry.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (clr_req_i) begin
          state_d = ST_SWEEP;
          idx_d   = ZERO_IDX;
        end else begin
          state_d = ST_IDLE;
          idx_d   = idx_q;
        end
      end
      ST_SWEEP: begin
        idx_d = idx_q + ADDR_W'(1);
        if (idx_q == LAST_IDX) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_SWEEP;
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = ZERO_IDX;
      end
    endcase
  end

  // Outputs decoded from the registered state only.
  always_comb begin
    clr_addr_o = idx_q;
    case (state_q)
      ST_SWEEP: begin
        clr_en_o = 1'b1;
        busy_o   = 1'b1;
      end
      ST_IDLE: begin
        clr_en_o = 1'b0;
        busy_o   = 1'b0;
      end
      default: begin
        clr_en_o = 1'b0;
        busy_o   = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/regfile_scb.sv
// Parametrised register file with pending-write scoreboard.
// Ports:
//   clk, rst_n            clock / asynchronous active-low reset
//   rd_addr1/2            read addresses; rd_data1/2 and rd_pend1/2 are combinational
//   wr_en/wr_addr/wr_data write port (also clears the pending bit)
//   rsv_en/rsv_addr       reserve a destination (sets the pending bit)
//   clr_req               start a bulk clear; clr_busy high while it runs
//   wr_drop               registered pulse: a write/reservation was discarded
// All state updates on the rising edge; same-cycle write data is forwarded
// to the read ports when BYPASS=1 and no sweep is running.
module regfile_scb
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic              rd_pend1,
  output logic              rd_pend2,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              wr_drop
);

  localparam int                DEPTH    = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ADDR_ZRO = {ADDR_W{1'b0}};
  localparam logic [DATA_W-1:0] DATA_ZRO = {DATA_W{1'b0}};

  logic [DATA_W-1:0] reg_q [DEPTH];
  logic [DATA_W-1:0] reg_d [DEPTH];
  logic [DEPTH-1:0]  pend_q, pend_d;
  logic              wr_drop_q, wr_drop_d;

  logic              clr_en;
  logic [ADDR_W-1:0] clr_addr;
  logic              busy;
  logic              wr_fire, rsv_fire, byp1, byp2;

  regfile_scb_sweep #(.ADDR_W(ADDR_W)) u_sweep (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_req_i (clr_req),
    .clr_en_o  (clr_en),
    .clr_addr_o(clr_addr),
    .busy_o    (busy)
  );

  // Address 0 is hardwired when ZERO_REG=1, so accesses to it are dropped
  // silently (no wr_drop); only sweep-time accesses raise wr_drop.
  assign wr_fire   = wr_en  && !busy && !((ZERO_REG != 0) && (wr_addr  == ADDR_ZRO));
  assign rsv_fire  = rsv_en && !busy && !((ZERO_REG != 0) && (rsv_addr == ADDR_ZRO));
  assign wr_drop_d = busy && (wr_en || rsv_en);
  assign byp1      = (BYPASS != 0) && wr_en && !busy && (wr_addr == rd_addr1);
  assign byp2      = (BYPASS != 0) && wr_en && !busy && (wr_addr == rd_addr2);

  // Per-entry next state; a reservation beats a write for the pending bit.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      if (clr_en && (clr_addr == ADDR_W'(i))) begin
        reg_d[i]  = DATA_ZRO;
        pend_d[i] = 1'b0;
      end else if (wr_fire && (wr_addr == ADDR_W'(i))) begin
        reg_d[i]  = wr_data;
        pend_d[i] = rsv_fire && (rsv_addr == ADDR_W'(i));
      end else if (rsv_fire && (rsv_addr == ADDR_W'(i))) begin
        reg_d[i]  = reg_q[i];
        pend_d[i] = 1'b1;
      end else begin
        reg_d[i]  = reg_q[i];
        pend_d[i] = pend_q[i];
      end
    end
  end

  // Array, scoreboard and drop-pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        reg_q[i] <= DATA_ZRO;
      end
      pend_q    <= {DEPTH{1'b0}};
      wr_drop_q <= 1'b0;
    end else begin
      reg_q     <= reg_d;
      pend_q    <= pend_d;
      wr_drop_q <= wr_drop_d;
    end
  end

  // Read port 1: zero register, then bypass, then array.
  always_comb begin
    if ((ZERO_REG != 0) && (rd_addr1 == ADDR_ZRO)) begin
      rd_data1 = DATA_ZRO;
      rd_pend1 = 1'b0;
    end else if (byp1) begin
      rd_data1 = wr_data;
      rd_pend1 = 1'b0;
    end else begin
      rd_data1 = reg_q[rd_addr1];
      rd_pend1 = pend_q[rd_addr1];
    end
  end

  // Read port 2: same priority as port 1.
  always_comb begin
    if ((ZERO_REG != 0) && (rd_addr2 == ADDR_ZRO)) begin
      rd_data2 = DATA_ZRO;
      rd_pend2 = 1'b0;
    end else if (byp2) begin
      rd_data2 = wr_data;
      rd_pend2 = 1'b0;
    end else begin
      rd_data2 = reg_q[rd_addr2];
      rd_pend2 = pend_q[rd_addr2];
    end
  end

  assign clr_busy = busy;
  assign wr_drop  = wr_drop_q;

endmodule

// File: tb/tb_regfile_scb.sv
module tb_regfile_scb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  rd_addr1, rd_addr2, wr_addr, rsv_addr;
  logic [31:0] wr_data;
  logic        wr_en, rsv_en, clr_req;

  logic [31:0] rd_data1_a, rd_data2_a, rd_data1_b, rd_data2_b;
  logic        rd_pend1_a, rd_pend2_a, rd_pend1_b, rd_pend2_b;
  logic        clr_busy_a, clr_busy_b, wr_drop_a, wr_drop_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  regfile_scb dut_a (
    .clk(clk), .rst_n(rst_n),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(rd_data1_a), .rd_data2(rd_data2_a),
    .rd_pend1(rd_pend1_a), .rd_pend2(rd_pend2_a),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .clr_req(clr_req), .clr_busy(clr_busy_a), .wr_drop(wr_drop_a)
  );

  regfile_scb #(.BYPASS(0)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(rd_data1_b), .rd_data2(rd_data2_b),
    .rd_pend1(rd_pend1_b), .rd_pend2(rd_pend2_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .clr_req(clr_req), .clr_busy(clr_busy_b), .wr_drop(wr_drop_b)
  );

  typedef struct {
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        rsv_en;
    logic [4:0]  rsv_addr;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] d1;
    logic        p1;
    logic [31:0] d2;
    logic        p2;
    logic        drop;
  } vec_t;

  vec_t vt [13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    wr_en = 1'b0; rsv_en = 1'b0; clr_req = 1'b0;
    wr_addr = 5'd0; wr_data = 32'h0; rsv_addr = 5'd0;
  endtask

  // Start a sweep at the current point (just after a negedge), count busy
  // cycles, probe a register mid-sweep and inject a write that must drop.
  task automatic run_sweep(input logic [4:0] probe, input logic [31:0] probe_val);
    int  cnt;
    bit  done;
    cnt  = 0;
    done = 1'b0;
    clr_req = 1'b1;
    for (int k = 1; k <= 100 && !done; k++) begin
      @(negedge clk);
      clr_req = 1'b0;
      wr_en   = 1'b0;
      #1;
      if (!clr_busy_a) begin
        done = 1'b1;
      end else begin
        cnt++;
        if (k == 3) begin
          rd_addr1 = probe;
          rd_addr2 = 5'd1;
          wr_en    = 1'b1;
          wr_addr  = 5'd3;
          wr_data  = 32'h0000FFFF;
          #1;
          chk("mid_sweep_probe", rd_data1_a, probe_val);
          chk("mid_sweep_cleared1", rd_data2_a, 32'h0);
        end
        if (k == 4) chk("drop_pulse", {31'd0, wr_drop_a}, 32'd1);
        if (k == 5) chk("drop_end", {31'd0, wr_drop_a}, 32'd0);
      end
    end
    chk("sweep_terminated", {31'd0, done}, 32'd1);
    chk("busy_cycles", cnt, 32'd32);
  endtask

  initial begin
    // wr_en wr_addr wr_data rsv_en rsv_addr ra1 ra2 | d1 p1 d2 p2 drop
    vt[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  5'd5,  5'd7,  32'hDEADBEEF, 1'b0, 32'h0,        1'b0, 1'b0};
    vt[1]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd5,  5'd0,  32'hDEADBEEF, 1'b0, 32'h0,        1'b0, 1'b0};
    vt[2]  = '{1'b1, 5'd0,  32'h00001234, 1'b1, 5'd0,  5'd0,  5'd5,  32'h0,        1'b0, 32'hDEADBEEF, 1'b0, 1'b0};
    vt[3]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd9,  5'd0,  5'd9,  32'h0,        1'b0, 32'h0,        1'b0, 1'b0};
    vt[4]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd0,  5'd9,  32'h0,        1'b0, 32'h0,        1'b1, 1'b0};
    vt[5]  = '{1'b1, 5'd9,  32'h00000055, 1'b0, 5'd0,  5'd0,  5'd9,  32'h0,        1'b0, 32'h00000055, 1'b0, 1'b0};
    vt[6]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd9,  5'd9,  32'h00000055, 1'b0, 32'h00000055, 1'b0, 1'b0};
    vt[7]  = '{1'b1, 5'd9,  32'h00000077, 1'b1, 5'd9,  5'd9,  5'd9,  32'h00000077, 1'b0, 32'h00000077, 1'b0, 1'b0};
    vt[8]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd9,  5'd9,  32'h00000077, 1'b1, 32'h00000077, 1'b1, 1'b0};
    vt[9]  = '{1'b1, 5'd12, 32'h00000001, 1'b1, 5'd13, 5'd12, 5'd13, 32'h00000001, 1'b0, 32'h0,        1'b0, 1'b0};
    vt[10] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd12, 5'd13, 32'h00000001, 1'b0, 32'h0,        1'b1, 1'b0};
    vt[11] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd12, 5'd12, 5'd5,  32'h00000001, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0};
    vt[12] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd12, 5'd20, 32'h00000001, 1'b1, 32'hCAFEF00D, 1'b0, 1'b0};

    idle_inputs();
    rd_addr1 = 5'd7;
    rd_addr2 = 5'd0;
    rst_n    = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset: write addr 7, then pull reset mid-cycle.
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h00000099; rd_addr1 = 5'd7;
    @(negedge clk);
    wr_en = 1'b0;
    #1 chk("pre_reset_data", rd_data1_a, 32'h00000099);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("reset_data", rd_data1_a, 32'h0);
    chk("reset_pend", {31'd0, rd_pend1_a}, 32'd0);
    chk("reset_busy", {31'd0, clr_busy_a}, 32'd0);
    chk("reset_drop", {31'd0, wr_drop_a}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Bypass on (dut_a) versus off (dut_b).
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 5'd20; wr_data = 32'hCAFEF00D; rd_addr1 = 5'd20;
    #1;
    chk("bypass_on", rd_data1_a, 32'hCAFEF00D);
    chk("bypass_off", rd_data1_b, 32'h0);
    @(negedge clk);
    wr_en = 1'b0;
    #1;
    chk("after_write_a", rd_data1_a, 32'hCAFEF00D);
    chk("after_write_b", rd_data1_b, 32'hCAFEF00D);

    // Table-driven vectors.
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      wr_en = vt[i].wr_en; wr_addr = vt[i].wr_addr; wr_data = vt[i].wr_data;
      rsv_en = vt[i].rsv_en; rsv_addr = vt[i].rsv_addr;
      rd_addr1 = vt[i].ra1; rd_addr2 = vt[i].ra2;
      #1;
      chk($sformatf("v%0d_d1", i), rd_data1_a, vt[i].d1);
      chk($sformatf("v%0d_p1", i), {31'd0, rd_pend1_a}, {31'd0, vt[i].p1});
      chk($sformatf("v%0d_d2", i), rd_data2_a, vt[i].d2);
      chk($sformatf("v%0d_p2", i), {31'd0, rd_pend2_a}, {31'd0, vt[i].p2});
      chk($sformatf("v%0d_drop", i), {31'd0, wr_drop_a}, {31'd0, vt[i].drop});
    end
    @(negedge clk);
    idle_inputs();

    // Bulk clear: preload 1..31 with data and pending bits.
    for (int a = 1; a < 32; a++) begin
      @(negedge clk);
      wr_en = 1'b1; wr_addr = 5'(a); wr_data = 32'hA5A5A5A5;
      rsv_en = 1'b1; rsv_addr = 5'(a);
    end
    @(negedge clk);
    idle_inputs();
    rd_addr1 = 5'd17; rd_addr2 = 5'd17;
    #1;
    chk("preload_data", rd_data1_a, 32'hA5A5A5A5);
    chk("preload_pend", {31'd0, rd_pend2_a}, 32'd1);
    run_sweep(5'd3, 32'hA5A5A5A5);
    for (int a = 0; a < 32; a++) begin
      rd_addr1 = 5'(a); rd_addr2 = 5'(a);
      #1;
      chk($sformatf("cleared_d%0d", a), rd_data1_a, 32'h0);
      chk($sformatf("cleared_p%0d", a), {31'd0, rd_pend2_a}, 32'd0);
    end

    // Reset in the middle of a sweep.
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 5'd30; wr_data = 32'h00000011;
    rsv_en = 1'b1; rsv_addr = 5'd31;
    @(negedge clk);
    idle_inputs();
    rd_addr1 = 5'd30; rd_addr2 = 5'd31;
    clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    repeat (9) @(negedge clk);
    #1 chk("sweep_active", {31'd0, clr_busy_a}, 32'd1);
    chk("sweep_untouched", rd_data1_a, 32'h00000011);
    #1 rst_n = 1'b0;
    #1;
    chk("midsweep_rst_busy", {31'd0, clr_busy_a}, 32'd0);
    chk("midsweep_rst_data", rd_data1_a, 32'h0);
    chk("midsweep_rst_pend", {31'd0, rd_pend2_a}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // New sweep must restart from index 0: addr 12 survives past cycle 3.
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 5'd12; wr_data = 32'h00000033;
    @(negedge clk);
    idle_inputs();
    run_sweep(5'd12, 32'h00000033);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
